// File: rtl/sq_wave_monitor_pkg.sv
// Shared definitions for the square-wave period monitor: FSM encoding,
// default widths and the saturation constant of the period counter.
package sq_wave_monitor_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int WINDOW_DEF = 256;

  // Counter value at which the monitor gives up waiting for an edge.
  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

endpackage

// File: rtl/sq_wave_monitor_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector. The rise pulse is combinational from the
// synchronized value and its delayed copy, so it lasts one clk cycle.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Bring the asynchronous input into the clk domain and keep one history bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d_async;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/sq_wave_monitor.sv
// Square-wave period monitor: measures each cycle of an asynchronous
// square wave in clk cycles, flags a stalled input, and publishes the
// min/max period over fixed-size windows of measurements.
module sq_wave_monitor
  import sq_wave_monitor_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sq_in,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
  output logic             stats_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               N_W     = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam logic [N_W-1:0]   N_LAST  = N_W'(WINDOW - 1);

  state_t           state;
  state_t           state_next;
  logic             rise;
  logic             emit;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] acc_min;
  logic [CNT_W-1:0] acc_max;
  logic [N_W-1:0]   n;
  logic [CNT_W-1:0] upd_min;
  logic [CNT_W-1:0] upd_max;
  logic             win_done;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (sq_in),
    .rise    (rise)
  );

  // Cycles since the last rising edge; restarts at 1 so a rise sees the exact period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNARMED;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the first edge and the edge after a stall only re-arm measurement.
  always_comb begin
    state_next = state;
    case (state)
      UNARMED: if (rise) state_next = MEASURE;
      MEASURE: begin
        if (rise) begin
          state_next = MEASURE;
        end else if (cnt == CNT_MAX) begin
          state_next = STALLED;
        end
      end
      STALLED: if (rise) state_next = MEASURE;
      default: state_next = UNARMED;
    endcase
  end

  // FSM outputs: a period is emitted only on an edge that closes a measured cycle.
  always_comb begin
    emit    = (state == MEASURE) && rise;
    stalled = (state == STALLED);
  end

  // Publish the measured period with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= emit;
      if (emit) begin
        period <= cnt;
      end
    end
  end

  // Running extremes including the period currently on the output.
  always_comb begin
    upd_min  = (period < acc_min) ? period : acc_min;
    upd_max  = (period > acc_max) ? period : acc_max;
    win_done = (n == N_LAST);
  end

  // Window accumulation; a clear in the same cycle as a new period drops that period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min     <= '1;
      acc_max     <= '0;
      n           <= '0;
      min_period  <= '0;
      max_period  <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (clr_stats) begin
        acc_min <= '1;
        acc_max <= '0;
        n       <= '0;
      end else if (period_valid) begin
        if (win_done) begin
          min_period  <= upd_min;
          max_period  <= upd_max;
          stats_valid <= 1'b1;
          acc_min     <= '1;
          acc_max     <= '0;
          n           <= '0;
        end else begin
          acc_min <= upd_min;
          acc_max <= upd_max;
          n       <= n + N_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sq_wave_monitor.sv
// Scoreboard bench for sq_wave_monitor with an 8-bit counter and 4-period windows.
module tb_sq_wave_monitor;

  logic       clk;
  logic       rst_n;
  logic       sq_in;
  logic       clr_stats;
  logic [7:0] period;
  logic       period_valid;
  logic [7:0] min_period;
  logic [7:0] max_period;
  logic       stats_valid;
  logic       stalled;

  int compared;
  int mismatched;
  int exp_period[$];
  int exp_min[$];
  int exp_max[$];
  bit prev_pv;
  bit clr_arm;
  int pv_seen;

  sq_wave_monitor #(.CNT_W(8), .WINDOW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sq_in        (sq_in),
    .clr_stats    (clr_stats),
    .period       (period),
    .period_valid (period_valid),
    .min_period   (min_period),
    .max_period   (max_period),
    .stats_valid  (stats_valid),
    .stalled      (stalled)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance n clock edges and settle 2 ns after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One square-wave cycle of p clk periods starting with a rising edge.
  task automatic applyStimulus(input int p, input bit expect_it);
    if (expect_it) exp_period.push_back(p);
    sq_in = 1'b1;
    waitCycles(p / 2);
    sq_in = 1'b0;
    waitCycles(p - p / 2);
  endtask

  // Closing rising edge, then let the pipeline drain.
  task automatic finishEdge();
    sq_in = 1'b1;
    waitCycles(3);
    sq_in = 1'b0;
    waitCycles(6);
  endtask

  task automatic pushStats(input int mn, input int mx);
    exp_min.push_back(mn);
    exp_max.push_back(mx);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sq_in = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"}, period, 0);
    checkOutput({tag, "_period_valid"}, period_valid, 0);
    checkOutput({tag, "_min_period"}, min_period, 0);
    checkOutput({tag, "_max_period"}, max_period, 0);
    checkOutput({tag, "_stats_valid"}, stats_valid, 0);
    checkOutput({tag, "_stalled"}, stalled, 0);
  endtask

  // Drives clr_stats during the cycle of the 3rd period_valid while armed.
  initial begin
    clr_stats = 1'b0;
    forever begin
      @(negedge clk);
      clr_stats = 1'b0;
      if (clr_arm && period_valid) begin
        pv_seen++;
        if (pv_seen == 3) clr_stats = 1'b1;
      end
    end
  end

  // Monitor: pops expected responses whenever the DUT strobes an output.
  initial begin
    int e;
    int em;
    int ex;
    prev_pv = 1'b0;
    forever begin
      @(negedge clk);
      if (period_valid) begin
        if (exp_period.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_period: got %0d, expected no period", period);
        end else begin
          e = exp_period.pop_front();
          checkOutput("period", period, e);
        end
      end
      if (stats_valid) begin
        checkOutput("stats_after_period_valid", prev_pv, 1);
        if (exp_min.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_stats: got min %0d max %0d, expected none",
                   min_period, max_period);
        end else begin
          em = exp_min.pop_front();
          ex = exp_max.pop_front();
          checkOutput("min_period", min_period, em);
          checkOutput("max_period", max_period, ex);
        end
      end
      prev_pv = period_valid;
    end
  end

  // Directed test sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    clr_arm    = 1'b0;
    pv_seen    = 0;
    rst_n      = 1'b0;
    sq_in      = 1'b0;
    #1;
    checkAllZero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] test 1: sq_in toggling every clk");
    pushStats(2, 2);
    pushStats(2, 2);
    for (int i = 0; i < 8; i++) applyStimulus(2, 1'b1);
    finishEdge();

    $display("[TB] test 2: periods 10,12,9,11");
    doReset();
    pushStats(9, 12);
    applyStimulus(10, 1'b1);
    applyStimulus(12, 1'b1);
    applyStimulus(9, 1'b1);
    applyStimulus(11, 1'b1);
    finishEdge();

    $display("[TB] test 3: stall and recovery");
    doReset();
    sq_in = 1'b1;
    waitCycles(5);
    sq_in = 1'b0;
    waitCycles(230);
    checkOutput("stalled_before_sat", stalled, 0);
    waitCycles(60);
    checkOutput("stalled_after_sat", stalled, 1);
    sq_in = 1'b1;
    waitCycles(5);
    checkOutput("stalled_cleared", stalled, 0);
    exp_period.push_back(20);
    sq_in = 1'b0;
    waitCycles(15);
    finishEdge();

    $display("[TB] test 4: clr_stats with 3rd period");
    doReset();
    pv_seen = 0;
    clr_arm = 1'b1;
    pushStats(12, 15);
    applyStimulus(10, 1'b1);
    applyStimulus(11, 1'b1);
    applyStimulus(6, 1'b1);
    applyStimulus(12, 1'b1);
    applyStimulus(13, 1'b1);
    applyStimulus(14, 1'b1);
    applyStimulus(15, 1'b1);
    finishEdge();
    clr_arm = 1'b0;

    $display("[TB] test 5: reset mid-window");
    doReset();
    applyStimulus(10, 1'b1);
    applyStimulus(10, 1'b1);
    sq_in = 1'b1;
    waitCycles(4);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    for (int i = 0; i < 4; i++) begin
      waitCycles(2);
      sq_in = ~sq_in;
    end
    sq_in = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(3);
    pushStats(9, 12);
    applyStimulus(9, 1'b1);
    applyStimulus(10, 1'b1);
    applyStimulus(11, 1'b1);
    applyStimulus(12, 1'b1);
    finishEdge();

    $display("[TB] test 6: 7.5-cycle asynchronous period");
    doReset();
    pushStats(7, 8);
    pushStats(7, 8);
    for (int k = 0; k < 4; k++) begin
      exp_period.push_back(7);
      exp_period.push_back(8);
    end
    for (int k = 0; k < 9; k++) begin
      sq_in = 1'b1;
      #30;
      sq_in = 1'b0;
      #45;
    end
    @(posedge clk);
    #2;
    waitCycles(8);

    checkOutput("period_queue_drained", exp_period.size(), 0);
    checkOutput("stats_queue_drained", exp_min.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
